mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port core memory bus between two requesters:
  - instruction fetch (IF port)
  - EX-stage data access (D port)
- Requester side uses the same req/ready handshake as the dram_* interface; a separate in-order read-response channel is added.
- Sits between the core (IF, EX, MEM stages) and the unified memory/bus bridge.
- Sequences grants: data-first priority, anti-starvation counter, grant lock while stalled, in-order tracking of outstanding reads.

Parameters:
- XLEN, 32, data/address width
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered reads (owner FIFO depth, ≥1)
- STARVE_LIMIT, 4, consecutive D grants allowed while IF is waiting before IF is forced

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF read request
- if_addr  in  XLEN  IF address
- if_ready  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  XLEN  IF read data
- d_req  in  1  data request
- d_write  in  1  1 = store
- d_wstrb  in  XLEN/8  byte strobes
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  XLEN  load data
- bus_req  out  1  bus request
- bus_write  out  1  bus store
- bus_wstrb  out  XLEN/8  bus strobes
- bus_addr  out  XLEN  bus address
- bus_wdata  out  XLEN  bus store data
- bus_ready  in  1  bus accepts request
- bus_rvalid  in  1  read response valid (reads only; writes get no response)
- bus_rdata  in  XLEN  read response data

Behaviour:
- Handshake:
  - A transfer occurs when bus_req & bus_ready.
  - The granted requester's ready = bus_ready & granted & its req; the other requester's ready is 0.
  - Requesters hold request fields stable until ready.
- Grant selection (combinational from registered state):
  - If lock=1: the owner is lock_owner.
  - Else, if both request: IF when starve_cnt == STARVE_LIMIT, otherwise D.
  - Else: whichever requests.
- Read blocking:
  - A read (IF, or D with d_write=0) is eligible only when the owner FIFO is not full.
  - A full FIFO blocks reads even when a pop occurs in the same cycle.
  - Writes are never blocked by the FIFO.
  - An ineligible request is treated as absent for selection.
- Lock:
  - Set when bus_req & ~bus_ready, recording lock_owner = current owner.
  - Cleared on the accepting cycle.
  - Guarantees bus_* fields are stable across a bus stall.
- Bus outputs:
  - bus_* mirror the selected requester's fields.
  - For IF: bus_write=0, bus_wstrb=0, bus_wdata=0.
  - bus_req=0 when nothing is eligible.
- Starvation counter (starve_cnt, 0..STARVE_LIMIT):
  - +1 on each D accept while if_req is pending.
  - Reset to 0 on an IF accept or when if_req=0.
  - Saturates at STARVE_LIMIT.
- Owner FIFO:
  - Push the owner ID on each accepted read.
  - Pop on bus_rvalid.
  - Response routing: if_rvalid = bus_rvalid & head==IF; d_rvalid likewise for D.
  - rdata is passed through to both ports unconditionally.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - bus_rvalid with an empty FIFO is a protocol error: ignored, no rvalid asserted, no pointer change.
- Latency: zero-cycle arbitration (request to bus_req in the same cycle); responses are combinational pass-through.
- Reset (rst=1 at posedge): lock=0, starve_cnt=0, FIFO empty. All outputs are then 0 except the combinational pass-throughs of rdata. The bus is reset together with this block, so in-flight responses are discarded.

Decomposition:
- Package mem_arb_pkg: owner_e {OWNER_IF=1'b0, OWNER_D=1'b1}, reuses XLEN from the shared config.
- Sub-module mem_arb_owner_fifo: parameterised depth/width sync FIFO with push, pop, full, empty and head outputs, sync active-high reset.

Test Plan:
- if_req and d_req (read) asserted in the same cycle, bus_ready=1 -> D granted first cycle (d_ready=1, bus_addr=d_addr), IF granted the next cycle.
- d_req held continuously with stores, if_req held, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D; starve_cnt returns to 0 after the IF grant.
- IF granted with bus_ready=0 for 3 cycles while d_req rises -> bus_addr stays if_addr and d_ready=0 throughout; IF is accepted in cycle 4.
- MAX_OUTSTANDING=2; two IF reads accepted, no responses, then a D read -> D blocked (bus_req=0), a D store is still accepted; after one bus_rvalid with rdata=0xDEADBEEF, if_rvalid=1 with that data and the D read is accepted the next cycle.
- Interleaved accepts IF read, D read, IF read, then 3 bus_rvalid -> rvalid delivered to IF, D, IF in order; push and pop in the same cycle keep the count correct.
- Assert rst mid-stall with lock=1 and FIFO count=2 -> next cycle FIFO empty, lock=0, starve_cnt=0, no rvalid on a subsequent spurious bus_rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and configuration for the memory arbiter
package mem_arb_pkg;

    localparam int CFG_XLEN = 32;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// rtl/mem_arb_owner_fifo.sv - small sync FIFO holding the owner of each outstanding read
module mem_arb_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // Overflow/underflow requests are dropped so the pointers never desynchronise.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF / data-port arbiter onto one single-port memory bus
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN            = CFG_XLEN,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [XLEN/8-1:0] d_wstrb,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          lock_q, lock_d;
    owner_e        lock_owner_q, lock_owner_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    owner_e owner;
    owner_e head_owner;
    logic   fifo_full, fifo_empty, fifo_head;
    logic   if_elig, d_elig, accept, fifo_push, fifo_pop;

    // Reads need a free owner slot; a same-cycle pop does not free one.
    assign if_elig = if_req & ~fifo_full;
    assign d_elig  = d_req & (d_write | ~fifo_full);

    always_comb begin
        owner   = OWNER_D;
        bus_req = 1'b0;
        if (lock_q) begin
            owner   = lock_owner_q;
            bus_req = (lock_owner_q == OWNER_IF) ? if_elig : d_elig;
        end else if (if_elig && d_elig) begin
            owner   = (starve_cnt_q == SW'(STARVE_LIMIT)) ? OWNER_IF : OWNER_D;
            bus_req = 1'b1;
        end else begin
            owner   = d_elig ? OWNER_D : OWNER_IF;
            bus_req = if_elig | d_elig;
        end
    end

    always_comb begin
        bus_write = 1'b0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_req) begin
            if (owner == OWNER_D) begin
                bus_write = d_write;
                bus_wstrb = d_wstrb;
                bus_addr  = d_addr;
                bus_wdata = d_wdata;
            end else begin
                bus_addr = if_addr;
            end
        end
    end

    assign accept    = bus_req & bus_ready;
    assign if_ready  = accept & (owner == OWNER_IF);
    assign d_ready   = accept & (owner == OWNER_D);
    assign fifo_push = accept & ~bus_write;
    assign fifo_pop  = bus_rvalid & ~fifo_empty;
    assign head_owner = owner_e'(fifo_head);

    assign if_rvalid = fifo_pop & (head_owner == OWNER_IF);
    assign d_rvalid  = fifo_pop & (head_owner == OWNER_D);
    assign if_rdata  = bus_rdata;
    assign d_rdata   = bus_rdata;

    always_comb begin
        lock_d       = bus_req & ~bus_ready;
        lock_owner_d = bus_req ? owner : lock_owner_q;
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_ready) begin
            starve_cnt_d = '0;
        end else if (d_ready && starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_IF;
            starve_cnt_q <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(1)
    ) u_owner_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(owner),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MAX_OUT = 2;
    localparam int LIMIT   = 4;

    typedef struct packed {
        logic        bus_req;
        logic        bus_write;
        logic [3:0]  bus_wstrb;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic        if_ready;
        logic        d_ready;
        logic        if_rvalid;
        logic        d_rvalid;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, if_rvalid, d_req, d_write, d_ready, d_rvalid;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, bus_wstrb;
    logic        bus_req, bus_write, bus_ready, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_write(bus_write), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: who is stalled on the bus, how many D wins IF has
    // watched, and the order in which reads are owed their data.
    bit   m_stalled;
    bit   m_stall_is_d;
    int   m_starve;
    bit   m_owed[$];
    bit   if_hold, d_hold;

    task automatic cycle(input int p_if, input int p_d, input int p_w,
                         input int p_rdy, input int p_rv, input int p_rst);
        obs_t e;
        bit   full, if_ok, d_ok, want, who_d, acc, got;
        @(negedge clk);
        if (!if_hold) begin
            if_req  = ($urandom_range(99) < p_if);
            if_addr = $urandom;
        end
        if (!d_hold) begin
            d_req   = ($urandom_range(99) < p_d);
            d_write = ($urandom_range(99) < p_w);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
        end
        bus_ready  = ($urandom_range(99) < p_rdy);
        bus_rvalid = ($urandom_range(99) < p_rv);
        bus_rdata  = $urandom;
        rst        = ($urandom_range(999) < p_rst);

        full  = (m_owed.size() >= MAX_OUT);
        if_ok = if_req && !full;
        d_ok  = d_req && (d_write || !full);
        if (m_stalled) begin
            who_d = m_stall_is_d;
            want  = who_d ? d_ok : if_ok;
        end else if (if_ok && d_ok) begin
            who_d = (m_starve != LIMIT);
            want  = 1'b1;
        end else begin
            who_d = d_ok;
            want  = if_ok || d_ok;
        end
        acc = want && bus_ready;

        e           = '0;
        e.bus_req   = want;
        e.if_rdata  = bus_rdata;
        e.d_rdata   = bus_rdata;
        if (want) begin
            e.bus_addr = who_d ? d_addr : if_addr;
            if (who_d) begin
                e.bus_write = d_write;
                e.bus_wstrb = d_wstrb;
                e.bus_wdata = d_wdata;
            end
        end
        e.if_ready = acc && !who_d;
        e.d_ready  = acc && who_d;
        got = bus_rvalid && (m_owed.size() > 0);
        if (got) begin
            if (m_owed[0]) e.d_rvalid = 1'b1;
            else           e.if_rvalid = 1'b1;
            void'(m_owed.pop_front());
        end
        exp_q.push_back(e);

        if (acc && !(who_d && d_write)) m_owed.push_back(who_d);
        if (!if_req || (acc && !who_d)) m_starve = 0;
        else if (acc && who_d && m_starve < LIMIT) m_starve++;
        m_stalled    = want && !bus_ready;
        m_stall_is_d = who_d;
        if (rst) begin
            m_stalled = 1'b0;
            m_starve  = 0;
            m_owed.delete();
        end
        if_hold = if_req && !(acc && !who_d);
        d_hold  = d_req && !(acc && who_d);
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus_req, bus_write, bus_wstrb, bus_addr, bus_wdata, if_ready,
                      d_ready, if_rvalid, d_rvalid, if_rdata, d_rdata};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_write = 0; d_wstrb = 0;
        d_addr = 0; d_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        m_stalled = 0; m_stall_is_d = 0; m_starve = 0; if_hold = 0; d_hold = 0;
        repeat (2) @(posedge clk);
        // idle after reset, including spurious responses with nothing owed
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 50, 50, 0);
        // mixed traffic, mostly reads, slow responses so the owner FIFO fills
        for (int i = 0; i < 1500; i++) cycle(60, 60, 30, 70, 25, 0);
        // IF nearly always waiting behind a stream of D stores
        for (int i = 0; i < 800; i++) cycle(95, 95, 90, 85, 30, 0);
        // frequent bus stalls with occasional resets landing mid-stall
        for (int i = 0; i < 1200; i++) cycle(70, 70, 40, 35, 30, 20);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
